// File: rtl/ysyx22041405_mem_arbiter.sv
// rtl/ysyx22041405_mem_arbiter.sv - two-requester (IF/LS) single-port memory arbiter
//
// Accepts one request at a time from the IF fetch port or the LS load/store
// port, latches it, issues it on the shared memory port with a valid/ready
// handshake, waits for the response and returns it as a one-cycle pulse to
// the requester that owns the transaction.
//
// Optional build macro: ARB_RR_EN
//   defined   -> round-robin on ties (requester not granted last wins)
//   undefined -> fixed priority, LS wins ties
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req_*  / if_resp_*         IF fetch request / response
//   ls_req_*  / ls_resp_*         LS load/store request / response
//   mem_req_valid/ready, mem_addr, mem_wdata, mem_we, mem_wmask
//                                 downstream request (latched fields)
//   mem_resp_valid, mem_resp_data downstream response
//   busy                          arbiter not idle
//   owner                         0 = IF, 1 = LS, current/last transaction

module ysyx22041405_mem_arbiter #(
    parameter int WIDTH  = 32,
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_valid,
    input  logic [WIDTH-1:0]  if_req_addr,
    output logic              if_req_ready,
    output logic              if_resp_valid,
    output logic [WIDTH-1:0]  if_resp_data,

    input  logic              ls_req_valid,
    input  logic [WIDTH-1:0]  ls_req_addr,
    input  logic              ls_req_we,
    input  logic [WIDTH-1:0]  ls_req_wdata,
    input  logic [MASK_W-1:0] ls_req_wmask,
    output logic              ls_req_ready,
    output logic              ls_resp_valid,
    output logic [WIDTH-1:0]  ls_resp_data,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_we,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [WIDTH-1:0]  mem_resp_data,

    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [WIDTH-1:0]    r_addr;
    logic [WIDTH-1:0]    r_wdata;
    logic                r_we;
    logic [MASK_W-1:0]   r_wmask;
    logic [WIDTH-1:0]    r_resp_data;
    // r_owner doubles as the last-grant register: it is rewritten on every
    // grant and resets to IF, exactly what the round-robin tie-break needs.
    logic                r_owner;

    logic                w_idle;
    logic                w_tie_ls;
    logic                w_grant_if;
    logic                w_grant_ls;

    assign w_idle = (r_state == S_IDLE);

`ifdef ARB_RR_EN
    // Tie goes to whoever was not granted last.
    assign w_tie_ls = ~r_owner;
`else
    // Older instruction (LS) always wins a tie.
    assign w_tie_ls = 1'b1;
`endif

    assign w_grant_ls = w_idle & ls_req_valid & (~if_req_valid | w_tie_ls);
    assign w_grant_if = w_idle & if_req_valid & ~w_grant_ls;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; responses outside WAIT are ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_if | w_grant_ls) w_next = S_ISSUE;
            S_ISSUE: if (mem_req_ready)           w_next = S_WAIT;
            S_WAIT:  if (mem_resp_valid)          w_next = S_RESP;
            S_RESP:                               w_next = S_IDLE;
            default:                              w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        if_req_ready  = w_grant_if;
        ls_req_ready  = w_grant_ls;
        mem_req_valid = (r_state == S_ISSUE);
        if_resp_valid = (r_state == S_RESP) & ~r_owner;
        ls_resp_valid = (r_state == S_RESP) &  r_owner;
        busy          = ~w_idle;
        owner         = r_owner;
        mem_addr      = r_addr;
        mem_wdata     = r_wdata;
        mem_we        = r_we;
        mem_wmask     = r_wmask;
        if_resp_data  = r_resp_data;
        ls_resp_data  = r_resp_data;
    end

    // Request/response latches. Request fields are captured only at the
    // grant, so requesters may drop them right after their ready pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_wmask     <= '0;
            r_owner     <= 1'b0;
            r_resp_data <= '0;
        end else begin
            if (w_grant_ls) begin
                r_addr  <= ls_req_addr;
                r_we    <= ls_req_we;
                r_wdata <= ls_req_wdata;
                r_wmask <= ls_req_wmask;
                r_owner <= 1'b1;
            end else if (w_grant_if) begin
                // Fetches are reads: scrub the write fields.
                r_addr  <= if_req_addr;
                r_we    <= 1'b0;
                r_wdata <= '0;
                r_wmask <= '0;
                r_owner <= 1'b0;
            end
            if ((r_state == S_WAIT) && mem_resp_valid) begin
                r_resp_data <= mem_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_ysyx22041405_mem_arbiter.sv
// tb/tb_ysyx22041405_mem_arbiter.sv - self-checking bench for ysyx22041405_mem_arbiter

module tb_ysyx22041405_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        ls_req_valid;
    logic [31:0] ls_req_addr;
    logic        ls_req_we;
    logic [31:0] ls_req_wdata;
    logic [7:0]  ls_req_wmask;
    logic        ls_req_ready;
    logic        ls_resp_valid;
    logic [31:0] ls_resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        busy;
    logic        owner;

    int n_vec;
    int n_err;
    bit m_last;   // model: last granted requester, 0 = IF, 1 = LS

    ysyx22041405_mem_arbiter #(.WIDTH(32), .MASK_W(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
        .if_req_ready(if_req_ready), .if_resp_valid(if_resp_valid),
        .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr),
        .ls_req_we(ls_req_we), .ls_req_wdata(ls_req_wdata),
        .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data),
        .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tie-break rule from the arbitration policy.
    function automatic bit tie_goes_ls(input bit last);
`ifdef ARB_RR_EN
        return (last == 1'b0);
`else
        return 1'b1;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_valid   = 0; if_req_addr  = 0;
        ls_req_valid   = 0; ls_req_addr  = 0; ls_req_we = 0;
        ls_req_wdata   = 0; ls_req_wmask = 0;
        mem_req_ready  = 0; mem_resp_valid = 0; mem_resp_data = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        step(); step();
        rst = 0;
        m_last = 0;
        #1;
        n_vec++;
        if ({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid,
             mem_req_valid, mem_we, busy, owner} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl got %b exp 00000000", {if_req_ready, ls_req_ready,
                     if_resp_valid, ls_resp_valid, mem_req_valid, mem_we, busy, owner});
        end
        n_vec++;
        if ({mem_addr, mem_wdata, mem_wmask} !== 72'h0) begin
            n_err++;
            $display("FAIL reset_mem got %h %h %h exp 0", mem_addr, mem_wdata, mem_wmask);
        end
        n_vec++;
        if ({if_resp_data, ls_resp_data} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_resp got %h %h exp 0", if_resp_data, ls_resp_data);
        end
    endtask

    // Both requesters valid continuously; memory always ready/responding.
    task automatic test_back_to_back();
        int got;
        bit exp_ls;
        got = 0;
        if_req_valid = 1; if_req_addr = 32'h1000;
        ls_req_valid = 1; ls_req_addr = 32'h2000; ls_req_we = 0;
        mem_req_ready = 1; mem_resp_valid = 1;
        for (int c = 0; c < 60 && got < 4; c++) begin
            mem_resp_data = $urandom;
            #1;
            n_vec++;
            if (if_req_ready && ls_req_ready) begin
                n_err++;
                $display("FAIL tie_both_ready got 11 exp one-hot");
            end
            if (if_req_ready || ls_req_ready) begin
                exp_ls = tie_goes_ls(m_last);
                n_vec++;
                if (ls_req_ready !== exp_ls) begin
                    n_err++;
                    $display("FAIL tie_grant%0d got ls=%b exp ls=%b", got, ls_req_ready, exp_ls);
                end
                m_last = exp_ls;
                got++;
            end
            step();
        end
        n_vec++;
        if (got != 4) begin
            n_err++;
            $display("FAIL tie_timeout got %0d grants exp 4", got);
        end
        if_req_valid = 0; ls_req_valid = 0;
        repeat (4) step();
        clear_inputs();
        #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL tie_drain got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_if_fetch();
        if_req_valid = 1; if_req_addr = 32'h8000_0000;
        #1;
        n_vec++;
        if ({if_req_ready, ls_req_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL fetch_ready got %b exp 10", {if_req_ready, ls_req_ready});
        end
        m_last = 0;
        step();
        if_req_valid = 0; if_req_addr = 32'h1234_5678; mem_req_ready = 1;
        #1;
        n_vec++;
        if ({mem_req_valid, mem_we, mem_wmask, mem_wdata, mem_addr, owner, busy} !==
            {1'b1, 1'b0, 8'h00, 32'h0, 32'h8000_0000, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL fetch_issue got v=%b we=%b m=%h wd=%h a=%h exp 1 0 00 0 80000000",
                     mem_req_valid, mem_we, mem_wmask, mem_wdata, mem_addr);
        end
        step();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h0000_0093;
        #1;
        n_vec++;
        if ({mem_req_valid, if_resp_valid, ls_resp_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL fetch_wait got %b exp 000", {mem_req_valid, if_resp_valid, ls_resp_valid});
        end
        step();
        mem_resp_valid = 0; mem_resp_data = 0;
        #1;
        n_vec++;
        if ({if_resp_valid, ls_resp_valid, if_resp_data} !== {2'b10, 32'h0000_0093}) begin
            n_err++;
            $display("FAIL fetch_resp got %b%b %h exp 10 00000093", if_resp_valid, ls_resp_valid, if_resp_data);
        end
        step();
        #1;
        n_vec++;
        if ({if_resp_valid, ls_resp_valid, busy, if_resp_data} !== {3'b000, 32'h0000_0093}) begin
            n_err++;
            $display("FAIL fetch_after got %b%b%b %h exp 000 00000093",
                     if_resp_valid, ls_resp_valid, busy, if_resp_data);
        end
    endtask

    task automatic test_ls_store_stall();
        logic [31:0] d;
        ls_req_valid = 1; ls_req_addr = 32'h8000_0100; ls_req_we = 1;
        ls_req_wdata = 32'hDEAD_BEEF; ls_req_wmask = 8'h0F;
        #1;
        n_vec++;
        if ({if_req_ready, ls_req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL store_ready got %b exp 01", {if_req_ready, ls_req_ready});
        end
        m_last = 1;
        step();
        for (int k = 0; k < 4; k++) begin
            ls_req_valid = 0; ls_req_addr = $urandom; ls_req_wdata = $urandom;
            ls_req_wmask = 8'($urandom); ls_req_we = 0;
            mem_req_ready = (k == 3);
            #1;
            n_vec++;
            if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask} !==
                {1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 8'h0F}) begin
                n_err++;
                $display("FAIL store_stall%0d got v=%b we=%b a=%h wd=%h m=%h exp 1 1 80000100 deadbeef 0f",
                         k, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask);
            end
            step();
        end
        mem_req_ready = 0;
        d = $urandom;
        mem_resp_valid = 1; mem_resp_data = d;
        step();
        mem_resp_valid = 0;
        #1;
        n_vec++;
        if ({if_resp_valid, ls_resp_valid, ls_resp_data} !== {2'b01, d}) begin
            n_err++;
            $display("FAIL store_resp got %b%b %h exp 01 %h", if_resp_valid, ls_resp_valid, ls_resp_data, d);
        end
        step();
        #1;
        n_vec++;
        if ({ls_resp_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL store_pulse got %b%b exp 00", ls_resp_valid, busy);
        end
        clear_inputs();
    endtask

    task automatic test_resp_in_issue();
        if_req_valid = 1; if_req_addr = 32'h8000_0040;
        #1;
        m_last = 0;
        step();
        if_req_valid = 0;
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hAAAA_0001;
        step();
        mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = 32'hAAAA_0002;
        step();
        mem_req_ready = 0; mem_resp_valid = 0;
        #1;
        n_vec++;
        if ({busy, mem_req_valid, if_resp_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL issue_ignore got %b exp 100", {busy, mem_req_valid, if_resp_valid});
        end
        step();
        mem_resp_valid = 1; mem_resp_data = 32'h5555_0003;
        step();
        mem_resp_valid = 1; mem_resp_data = 32'h7777_0004;
        #1;
        n_vec++;
        if ({if_resp_valid, if_resp_data} !== {1'b1, 32'h5555_0003}) begin
            n_err++;
            $display("FAIL issue_resp got %b %h exp 1 55550003", if_resp_valid, if_resp_data);
        end
        step();
        clear_inputs();
        #1;
        n_vec++;
        if ({if_resp_valid, busy, if_resp_data} !== {2'b00, 32'h5555_0003}) begin
            n_err++;
            $display("FAIL resp_hold got %b%b %h exp 00 55550003", if_resp_valid, busy, if_resp_data);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] d;
        ls_req_valid = 1; ls_req_addr = 32'h8000_0200; ls_req_we = 0;
        #1;
        step();
        ls_req_valid = 0; mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        #1;
        n_vec++;
        if ({busy, mem_req_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL rstw_wait got %b exp 10", {busy, mem_req_valid});
        end
        rst = 1; mem_resp_valid = 1; mem_resp_data = 32'hBAD0_BAD0;
        step();
        n_vec++;
        if ({busy, mem_req_valid, if_resp_valid, ls_resp_valid} !== 4'b0000) begin
            n_err++;
            $display("FAIL rstw_idle got %b exp 0000", {busy, mem_req_valid, if_resp_valid, ls_resp_valid});
        end
        rst = 0; mem_resp_valid = 0; m_last = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if ({busy, if_resp_valid, ls_resp_valid} !== 3'b000) begin
                n_err++;
                $display("FAIL rstw_quiet%0d got %b exp 000", k, {busy, if_resp_valid, ls_resp_valid});
            end
        end
        d = $urandom;
        if_req_valid = 1; if_req_addr = 32'h8000_0300;
        #1;
        n_vec++;
        if (if_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstw_regrant got %b exp 1", if_req_ready);
        end
        step();
        if_req_valid = 0; mem_req_ready = 1;
        step();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = d;
        step();
        mem_resp_valid = 0;
        #1;
        n_vec++;
        if ({if_resp_valid, ls_resp_valid, if_resp_data} !== {2'b10, d}) begin
            n_err++;
            $display("FAIL rstw_serve got %b%b %h exp 10 %h", if_resp_valid, ls_resp_valid, if_resp_data, d);
        end
        step();
        clear_inputs();
    endtask

    // Random requesters, fields and memory latencies against a transaction-level model.
    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int          r, rd, dd;
            bit          vi, vl, e_ls;
            logic [31:0] ai, al, wd, e_addr, e_wd, rdata;
            logic [7:0]  wm, e_wm;
            logic        we, e_we;
            r  = $urandom_range(1, 3);
            vi = (r != 2); vl = (r != 1);
            ai = $urandom; al = $urandom; wd = $urandom; wm = 8'($urandom); we = 1'($urandom);
            e_ls   = vl && (!vi || tie_goes_ls(m_last));
            e_addr = e_ls ? al : ai;
            e_we   = e_ls & we;
            e_wd   = e_ls ? wd : 32'h0;
            e_wm   = e_ls ? wm : 8'h0;
            if_req_valid = vi; if_req_addr = ai;
            ls_req_valid = vl; ls_req_addr = al; ls_req_we = we;
            ls_req_wdata = wd; ls_req_wmask = wm;
            #1;
            n_vec++;
            if ({if_req_ready, ls_req_ready} !== {!e_ls, e_ls}) begin
                n_err++;
                $display("FAIL rnd%0d_grant got %b%b exp %b%b", t, if_req_ready, ls_req_ready, !e_ls, e_ls);
            end
            m_last = e_ls;
            step();
            if_req_valid = 0; ls_req_valid = 0;
            if_req_addr = $urandom; ls_req_addr = $urandom; ls_req_wdata = $urandom;
            rd = $urandom_range(0, 3);
            for (int k = 0; k <= rd; k++) begin
                mem_req_ready  = (k == rd);
                mem_resp_valid = 1'($urandom);
                mem_resp_data  = $urandom;
                #1;
                n_vec++;
                if ({mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask} !==
                    {1'b1, e_addr, e_we, e_wd, e_wm}) begin
                    n_err++;
                    $display("FAIL rnd%0d_issue got %b %h %b %h %h exp 1 %h %b %h %h", t,
                             mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wmask,
                             e_addr, e_we, e_wd, e_wm);
                end
                step();
            end
            mem_req_ready = 0;
            dd = $urandom_range(0, 3);
            for (int k = 0; k < dd; k++) begin
                mem_resp_valid = 0;
                #1;
                n_vec++;
                if ({mem_req_valid, if_resp_valid, ls_resp_valid} !== 3'b000) begin
                    n_err++;
                    $display("FAIL rnd%0d_wait got %b exp 000", t, {mem_req_valid, if_resp_valid, ls_resp_valid});
                end
                step();
            end
            rdata = $urandom;
            mem_resp_valid = 1; mem_resp_data = rdata;
            step();
            mem_resp_valid = 1'($urandom); mem_resp_data = $urandom;
            #1;
            n_vec++;
            if ({if_resp_valid, ls_resp_valid, owner, (e_ls ? ls_resp_data : if_resp_data)} !==
                {!e_ls, e_ls, e_ls, rdata}) begin
                n_err++;
                $display("FAIL rnd%0d_resp got %b%b o=%b %h/%h exp %b%b o=%b %h", t,
                         if_resp_valid, ls_resp_valid, owner, if_resp_data, ls_resp_data,
                         !e_ls, e_ls, e_ls, rdata);
            end
            step();
            mem_resp_valid = 0;
            #1;
            n_vec++;
            if ({busy, if_resp_valid, ls_resp_valid} !== 3'b000) begin
                n_err++;
                $display("FAIL rnd%0d_idle got %b exp 000", t, {busy, if_resp_valid, ls_resp_valid});
            end
        end
        clear_inputs();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_last = 0;
        rst = 1;
        clear_inputs();
        test_reset();
        test_back_to_back();
        step();
        test_if_fetch();
        step();
        test_ls_store_stall();
        step();
        test_resp_in_issue();
        step();
        test_reset_in_wait();
        step();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx22041405_mem_arbiter.md
# ysyx22041405_mem_arbiter

Two-requester, single-port data-memory arbiter sitting between the instruction-fetch stage (IF) and the load/store stage (LS) on one side and the shared memory port on the other. It accepts one request at a time, latches it, issues it downstream with a valid/ready handshake, waits for the response, and returns it to the owning requester. It exists so that IF fetches and LS loads/stores can share one memory without colliding.

## Interface
- WIDTH, 32, address/data width
- MASK_W, 8, write byte-mask width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_valid  in  1  IF fetch request
- if_req_addr  in  WIDTH  fetch address
- if_req_ready  out  1  IF request accepted this cycle
- if_resp_valid  out  1  one-cycle pulse, fetch data valid
- if_resp_data  out  WIDTH  fetched word
- ls_req_valid  in  1  LS request
- ls_req_addr  in  WIDTH  load/store address
- ls_req_we  in  1  1 = store
- ls_req_wdata  in  WIDTH  store data
- ls_req_wmask  in  MASK_W  store byte mask
- ls_req_ready  out  1  LS request accepted this cycle
- ls_resp_valid  out  1  one-cycle pulse, load data / store ack
- ls_resp_data  out  WIDTH  load data (store: don't-care, driven with memory value)
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts
- mem_addr, mem_wdata  out  WIDTH  latched request fields
- mem_we  out  1  latched write enable
- mem_wmask  out  MASK_W  latched mask
- mem_resp_valid  in  1  downstream response valid
- mem_resp_data  in  WIDTH  downstream response data
- busy  out  1  state != IDLE
- owner  out  1  0 = IF, 1 = LS; owner of current/last transaction

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant one; winner's req_ready = 1 combinationally that cycle; latch addr/we/wdata/wmask and owner; next ISSUE. No request -> stay IDLE.
- IF grants force latched we = 0, wmask = 0, wdata = 0.
- ISSUE: mem_req_valid = 1 with latched fields held stable; on mem_req_ready -> WAIT.
- WAIT: on mem_resp_valid latch mem_resp_data -> RESP.
- RESP: owner's resp_valid = 1 for exactly one cycle with latched data; other resp_valid = 0; next IDLE.
- req_ready is 0 in every state except IDLE; at most one of if_req_ready/ls_req_ready high.
- Tie (both valid in IDLE): see Configuration.
- mem_resp_valid in IDLE/ISSUE/RESP: ignored, no state change.
- Requester must hold req fields only until its ready pulse; arbiter never rereads them.

## Timing
- Reset values: state = IDLE, all *_ready = 0, all *_resp_valid = 0, mem_req_valid = 0, mem_we = 0, mem_addr/mem_wdata/mem_wmask/resp data = 0, busy = 0, owner = 0, last-grant register = IF.
- Accept at T; mem_req_valid from T+1; with ready at T+1 and resp at T+2, resp_valid at T+3; next accept earliest T+4.
- Wait states in mem_req_ready or mem_resp_valid extend ISSUE/WAIT indefinitely; no timeout.
- Reset mid-transaction: immediate return to IDLE, in-flight response dropped, no resp_valid emitted.
- resp data registers hold value until next RESP.

## Configuration
- ARB_RR_EN defined: round-robin on ties; winner is the requester not granted last (last-grant register updated on every grant, reset = IF, so first tie goes to LS).
- ARB_RR_EN undefined: fixed priority, LS always wins ties (older instruction first); IF can starve while LS is continuously valid — accepted.

## Test plan
- Single IF fetch addr 0x8000_0000, mem ready immediately, resp 0x0000_0093 one cycle later -> if_req_ready at T, mem_req_valid T+1 with we=0 mask=0, if_resp_valid T+3 data 0x0000_0093, ls_resp_valid never.
- LS store addr 0x8000_0100 wdata 0xDEAD_BEEF mask 0x0F, mem_req_ready held low 3 cycles -> mem fields stable through stall, mem_we=1, ls_resp_valid one pulse after response.
- Both valid every cycle, 4 transactions -> with ARB_RR_EN grants LS,IF,LS,IF; without, LS,LS,LS,LS.
- mem_resp_valid pulsed during ISSUE -> ignored; only response in WAIT returned.
- rst asserted in WAIT -> next edge busy=0, mem_req_valid=0, no resp_valid; new IF request after release served normally.
